// File: rtl/march_pkg.sv
// March C- BIST shared definitions.
// Holds the controller state encoding, the March element index type and
// per-element attributes (address direction, ops per address, data
// polarity of the read expectation and of the write data).
package march_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic [2:0] elem_t;

    localparam int    NUM_ELEMS = 6;
    localparam elem_t LAST_ELEM = 3'd5;

    // M3 and M4 walk the array from the top address downwards.
    function automatic logic elem_is_down(input elem_t e);
        logic r;
        case (e)
            3'd3, 3'd4: r = 1'b1;
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

    // M1..M4 perform a read then a write at each address; M0 and M5 one op.
    function automatic logic elem_two_op(input elem_t e);
        logic r;
        case (e)
            3'd1, 3'd2, 3'd3, 3'd4: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // Reads in M2 and M4 expect the all-ones word, every other read all-zeros.
    function automatic logic elem_rd_ones(input elem_t e);
        logic r;
        case (e)
            3'd2, 3'd4: r = 1'b1;
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

    // Writes in M1 and M3 store the all-ones word, M0/M2/M4 store all-zeros.
    function automatic logic elem_wr_ones(input elem_t e);
        logic r;
        case (e)
            3'd1, 3'd3: r = 1'b1;
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/march_addr_gen.sv
// Loadable up/down address counter for the March sequencer.
// Ports: clk, rst (sync, active-high); load/load_top preset the counter to
// N-1 (load_top=1) or 0; step moves one address in direction 'down';
// addr is the current address; last flags the final address of the walk.
module march_addr_gen #(
    parameter int size = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            load_top,
    input  logic            step,
    input  logic            down,
    output logic [size-1:0] addr,
    output logic            last
);

    localparam logic [size-1:0] ADDR_ZERO = {size{1'b0}};
    localparam logic [size-1:0] ADDR_TOP  = {size{1'b1}};
    localparam logic [size-1:0] ADDR_ONE  = {{(size-1){1'b0}}, 1'b1};

    logic [size-1:0] addr_r;

    // Address register: load has priority over stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= ADDR_ZERO;
        end else if (load) begin
            addr_r <= load_top ? ADDR_TOP : ADDR_ZERO;
        end else if (step) begin
            addr_r <= down ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
        end else begin
            addr_r <= addr_r;
        end
    end

    // End-of-walk detect depends on the direction of the current element.
    always_comb begin
        if (down) begin
            last = (addr_r == ADDR_ZERO);
        end else begin
            last = (addr_r == ADDR_TOP);
        end
    end

    assign addr = addr_r;

endmodule

// File: rtl/march_controller.sv
// March C- memory BIST controller with functional-port bypass.
// Ports: clk, rst (sync, active-high); start launches a run from IDLE/DONE;
// csin/rwbarin/address/datain are the functional SRAM port, forwarded to
// mem_* whenever busy=0; mem_rdata returns read data one cycle after a read.
// busy marks BIST ownership; done/fail/fail_addr/fail_elem report the run,
// with fail_addr/fail_elem holding the first mismatch only.
module march_controller
    import march_pkg::*;
#(
    parameter int size   = 6,
    parameter int length = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              csin,
    input  logic              rwbarin,
    input  logic [size-1:0]   address,
    input  logic [length-1:0] datain,
    output logic              mem_cs,
    output logic              mem_rwbar,
    output logic [size-1:0]   mem_addr,
    output logic [length-1:0] mem_wdata,
    input  logic [length-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [size-1:0]   fail_addr,
    output logic [2:0]        fail_elem
);

    localparam logic [length-1:0] WORD_ONES  = {length{1'b1}};
    localparam logic [length-1:0] WORD_ZEROS = {length{1'b0}};

    state_e            state_r, next_state_s;
    elem_t             elem_r, next_elem_s;
    logic              op_r;
    logic              launch_s, addr_done_s, bist_read_s;
    logic              ag_load_s, ag_load_top_s, ag_step_s;
    logic [size-1:0]   ag_addr_s;
    logic              ag_last_s;
    logic              cmp_valid_r;
    logic [length-1:0] exp_r;
    logic [size-1:0]   cmp_addr_r;
    elem_t             cmp_elem_r;
    logic              fail_r, done_r;
    logic [size-1:0]   fail_addr_r;
    elem_t             fail_elem_r;

    march_addr_gen #(.size(size)) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (ag_load_s),
        .load_top (ag_load_top_s),
        .step     (ag_step_s),
        .down     (elem_is_down(elem_r)),
        .addr     (ag_addr_s),
        .last     (ag_last_s)
    );

    // Next-state and sequencing decisions for the current BIST cycle.
    always_comb begin
        next_state_s  = state_r;
        next_elem_s   = elem_r + 3'd1;
        launch_s      = 1'b0;
        addr_done_s   = 1'b0;
        bist_read_s   = 1'b0;
        ag_load_s     = 1'b0;
        ag_load_top_s = 1'b0;
        ag_step_s     = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    next_state_s = RUN;
                    launch_s     = 1'b1;
                    ag_load_s    = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            RUN: begin
                // op_r=0 is the read half of a two-op element; M5 only reads.
                bist_read_s = elem_two_op(elem_r) ? ~op_r : (elem_r == LAST_ELEM);
                addr_done_s = elem_two_op(elem_r) ? op_r : 1'b1;
                if (addr_done_s) begin
                    if (ag_last_s) begin
                        if (elem_r == LAST_ELEM) begin
                            next_state_s = DRAIN;
                        end else begin
                            ag_load_s     = 1'b1;
                            ag_load_top_s = elem_is_down(next_elem_s);
                        end
                    end else begin
                        ag_step_s = 1'b1;
                    end
                end else begin
                    ag_step_s = 1'b0;
                end
            end
            DRAIN:   next_state_s = DONE;
            default: next_state_s = IDLE;
        endcase
    end

    // State, element index and read/write phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            elem_r  <= 3'd0;
            op_r    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (launch_s) begin
                elem_r <= 3'd0;
                op_r   <= 1'b0;
            end else if (state_r == RUN) begin
                op_r <= ~addr_done_s;
                if (addr_done_s && ag_last_s && (elem_r != LAST_ELEM)) begin
                    elem_r <= next_elem_s;
                end else begin
                    elem_r <= elem_r;
                end
            end else begin
                elem_r <= elem_r;
                op_r   <= op_r;
            end
        end
    end

    // Expected-data pipeline: tags each BIST read for comparison next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_valid_r <= 1'b0;
            exp_r       <= WORD_ZEROS;
            cmp_addr_r  <= {size{1'b0}};
            cmp_elem_r  <= 3'd0;
        end else begin
            cmp_valid_r <= bist_read_s;
            exp_r       <= elem_rd_ones(elem_r) ? WORD_ONES : WORD_ZEROS;
            cmp_addr_r  <= ag_addr_s;
            cmp_elem_r  <= elem_r;
        end
    end

    // Run results: sticky fail with first-mismatch capture, done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_r      <= 1'b0;
            fail_addr_r <= {size{1'b0}};
            fail_elem_r <= 3'd0;
            done_r      <= 1'b0;
        end else if (launch_s) begin
            fail_r      <= 1'b0;
            fail_addr_r <= {size{1'b0}};
            fail_elem_r <= 3'd0;
            done_r      <= 1'b0;
        end else begin
            // done follows the DONE state by one edge so fail is already final.
            if (state_r == DONE) begin
                done_r <= 1'b1;
            end else begin
                done_r <= done_r;
            end
            if (cmp_valid_r && (mem_rdata != exp_r)) begin
                fail_r <= 1'b1;
                if (!fail_r) begin
                    fail_addr_r <= cmp_addr_r;
                    fail_elem_r <= cmp_elem_r;
                end else begin
                    fail_addr_r <= fail_addr_r;
                    fail_elem_r <= fail_elem_r;
                end
            end else begin
                fail_r      <= fail_r;
                fail_addr_r <= fail_addr_r;
                fail_elem_r <= fail_elem_r;
            end
        end
    end

    // SRAM port ownership: BIST drives while busy, functional port otherwise.
    always_comb begin
        busy = (state_r == RUN) || (state_r == DRAIN);
        if (busy) begin
            mem_cs    = (state_r == RUN);
            mem_rwbar = (state_r == RUN) ? bist_read_s : 1'b1;
            mem_addr  = ag_addr_s;
            mem_wdata = elem_wr_ones(elem_r) ? WORD_ONES : WORD_ZEROS;
        end else begin
            mem_cs    = csin;
            mem_rwbar = rwbarin;
            mem_addr  = address;
            mem_wdata = datain;
        end
    end

    assign done      = done_r;
    assign fail      = fail_r;
    assign fail_addr = fail_addr_r;
    assign fail_elem = fail_elem_r;

endmodule

// File: tb/tb_march_controller.sv
// Directed bench for march_controller with a behavioural SRAM that can
// inject one stuck-at-1 and one stuck-at-0 bit mask at chosen addresses.
module tb_march_controller;

    logic       clk = 1'b0;
    logic       rst, start, csin, rwbarin;
    logic [5:0] address;
    logic [7:0] datain;
    logic       mem_cs, mem_rwbar;
    logic [5:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic       busy, done, fail;
    logic [5:0] fail_addr;
    logic [2:0] fail_elem;

    logic [7:0] sram [0:63];
    logic [5:0] sa1_addr, sa0_addr;
    logic [7:0] sa1_mask, sa0_mask;

    int n_checks = 0;
    int n_errors = 0;
    int edges;

    march_controller #(.size(6), .length(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .csin      (csin),
        .rwbarin   (rwbarin),
        .address   (address),
        .datain    (datain),
        .mem_cs    (mem_cs),
        .mem_rwbar (mem_rwbar),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] faulty(input logic [5:0] a, input logic [7:0] w);
        logic [7:0] r;
        r = w;
        if (a == sa1_addr) r = r | sa1_mask;
        if (a == sa0_addr) r = r & ~sa0_mask;
        return r;
    endfunction

    // Behavioural SRAM: write on the edge, read data registered for next cycle.
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_rwbar) mem_rdata <= faulty(mem_addr, sram[mem_addr]);
            else           sram[mem_addr] <= mem_wdata;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch a run, optionally pulse start again at edge restart_at, count
    // edges from the start-sampling edge until done rises.
    task automatic run_bist(input int restart_at, input bit probe, output int n);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val("busy_rise", 32'(busy), 32'd1);
        check_val("done_clr", 32'(done), 32'd0);
        if (probe) begin
            check_val("m0_first", {21'd0, mem_cs, mem_rwbar, mem_wdata, mem_addr},
                      {21'd0, 1'b1, 1'b0, 8'h00, 6'd0});
        end
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            start = (n == restart_at);
            if (probe) begin
                if (n == 1)   check_val("m0_addr1", 32'(mem_addr), 32'd1);
                if (n == 64)  check_val("m1_rd0", {24'd0, mem_cs, mem_rwbar, mem_addr}, {24'd0, 1'b1, 1'b1, 6'd0});
                if (n == 65)  check_val("m1_wr0", {23'd0, mem_rwbar, mem_wdata}, {23'd0, 1'b0, 8'hFF});
                if (n == 320) check_val("m3_rd63", {24'd0, mem_cs, mem_rwbar, mem_addr}, {24'd0, 1'b1, 1'b1, 6'd63});
                if (n == 639) check_val("m5_last", {24'd0, mem_cs, mem_rwbar, mem_addr}, {24'd0, 1'b1, 1'b1, 6'd63});
                if (n == 640) check_val("drain", {30'd0, busy, mem_cs}, {30'd0, 1'b1, 1'b0});
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; csin = 1'b0; rwbarin = 1'b1;
        address = 6'd0; datain = 8'h00;
        sa1_addr = 6'd0; sa0_addr = 6'd0; sa1_mask = 8'h00; sa0_mask = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_state", {20'd0, busy, done, fail, fail_addr, fail_elem}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Functional write then read through the bypass.
        csin = 1'b1; rwbarin = 1'b0; address = 6'd5; datain = 8'hDE;
        #1;
        check_val("bypass_wr", {16'd0, mem_cs, mem_rwbar, mem_addr, mem_wdata},
                  {16'd0, 1'b1, 1'b0, 6'd5, 8'hDE});
        @(negedge clk);
        rwbarin = 1'b1;
        @(posedge clk);
        #1;
        check_val("bypass_rd", 32'(mem_rdata), 32'hDE);

        // Fault-free run with functional traffic that must be ignored.
        @(negedge clk);
        rwbarin = 1'b0; datain = 8'h55;
        run_bist(-1, 1'b1, edges);
        check_val("clean_edges", 32'(edges), 32'd642);
        check_val("clean_fail", 32'(fail), 32'd0);
        check_val("clean_idle", 32'(busy), 32'd0);
        csin = 1'b0;

        // Stuck-at-1 bit 0 at address 3: caught by first read of M1.
        sa1_addr = 6'd3; sa1_mask = 8'h01;
        run_bist(-1, 1'b0, edges);
        check_val("sa1_edges", 32'(edges), 32'd642);
        check_val("sa1_res", {22'd0, fail, fail_addr, fail_elem}, {22'd0, 1'b1, 6'd3, 3'd1});

        // Results survive a functional access.
        @(negedge clk);
        csin = 1'b1; rwbarin = 1'b0; address = 6'd9; datain = 8'h12;
        @(posedge clk);
        #1;
        check_val("hold_res", {21'd0, done, fail, fail_addr, fail_elem, mem_addr[0]},
                  {21'd0, 1'b1, 1'b1, 6'd3, 3'd1, 1'b1});
        @(negedge clk);
        csin = 1'b0;

        // Stuck-at-0 bit 7 at address 60: caught by M2 reading all-ones.
        sa1_mask = 8'h00; sa0_addr = 6'd60; sa0_mask = 8'h80;
        run_bist(-1, 1'b0, edges);
        check_val("sa0_edges", 32'(edges), 32'd642);
        check_val("sa0_res", {22'd0, fail, fail_addr, fail_elem}, {22'd0, 1'b1, 6'd60, 3'd2});

        // Second start mid-run is ignored.
        sa0_mask = 8'h00;
        run_bist(100, 1'b0, edges);
        check_val("restart_edges", 32'(edges), 32'd642);
        check_val("restart_fail", 32'(fail), 32'd0);

        // Reset during M3 aborts the run and clears all results.
        sa1_mask = 8'h01;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (330) @(posedge clk);
        #1;
        check_val("pre_rst", {30'd0, busy, fail}, {30'd0, 1'b1, 1'b1});
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("mid_rst", {20'd0, busy, done, fail, fail_addr, fail_elem}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sa1_mask = 8'h00;
        run_bist(-1, 1'b0, edges);
        check_val("post_rst_edges", 32'(edges), 32'd642);
        check_val("post_rst_fail", 32'(fail), 32'd0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_over_start", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        check_val("stay_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/march_controller.md
MARCH_CONTROLLER -- requirements
Module: march_controller

Interface
REQ-001 Parameter: size, default 6, SRAM address width; depth N = 2**size.
REQ-002 Parameter: length, default 8, SRAM data width.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle BIST launch request.
REQ-006 csin  in  1  functional chip-select.
REQ-007 rwbarin  in  1  functional read(1)/write(0).
REQ-008 address  in  size  functional address.
REQ-009 datain  in  length  functional write data.
REQ-010 mem_cs  out  1  SRAM chip-select.
REQ-011 mem_rwbar  out  1  SRAM read(1)/write(0).
REQ-012 mem_addr  out  size  SRAM address.
REQ-013 mem_wdata  out  length  SRAM write data.
REQ-014 mem_rdata  in  length  SRAM read data, valid the cycle after the read is presented.
REQ-015 busy  out  1  BIST owns the SRAM port.
REQ-016 done  out  1  BIST complete; held until next start or reset.
REQ-017 fail  out  1  sticky mismatch flag for the current/last run.
REQ-018 fail_addr  out  size  address of the first mismatch.
REQ-019 fail_elem  out  3  March element index (0-5) of the first mismatch.

Function
REQ-020 Algorithm: March C-: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0); "0" = all-zeros word, "1" = all-ones word.
REQ-021 One SRAM operation per cycle, no gaps; total 10*N operation cycles (640 at defaults).
REQ-022 States: IDLE, RUN, DRAIN, DONE.
REQ-023 IDLE/DONE + start=1 -> RUN; first op (M0 w0, addr 0) presented on mem_* the next cycle; fail, fail_addr, fail_elem, done cleared at that edge.
REQ-024 RUN -> DRAIN after the last M5 read is presented; DRAIN lasts one cycle (final compare); DRAIN -> DONE.
REQ-025 Up elements run address 0..N-1; down elements run N-1..0; element advances after its last address with no idle cycle.
REQ-026 Within two-op elements, read precedes write at the same address in consecutive cycles.
REQ-027 Compare: mem_rdata checked against the expected word one cycle after each BIST read; on mismatch fail is set at the following edge.
REQ-028 fail_addr/fail_elem capture only the first mismatch; later mismatches leave them unchanged.
REQ-029 busy=1 in RUN and DRAIN, else 0.
REQ-030 When busy=0: mem_cs/mem_rwbar/mem_addr/mem_wdata combinationally equal csin/rwbarin/address/datain.
REQ-031 When busy=1: functional inputs ignored (dropped, not queued); mem_cs=1 for every BIST cycle except DRAIN (mem_cs=0).
REQ-032 start while busy=1 ignored.
REQ-033 Results (done, fail, fail_addr, fail_elem) remain valid in DONE and through functional accesses.

Reset
REQ-034 rst=1 at any edge, including mid-RUN -> IDLE; busy=0, done=0, fail=0, fail_addr=0, fail_elem=0, address/element counters=0.
REQ-035 rst has priority over start in the same cycle; no pending compare survives reset.

Structure
REQ-036 Shared package march_pkg: state enum, element index type, NUM_ELEMS=6, per-element direction, op-count and expected-read/write-data constants.
REQ-037 One sub-module march_addr_gen: loadable up/down address counter with last-address flag.
REQ-038 Expected-data pipeline register and first-fail capture live in march_controller.

Verification
REQ-039 Fault-free behavioural SRAM, start pulse -> busy rises next cycle; done=1 exactly 642 edges after the start-sampling edge; fail=0.
REQ-040 Stuck-at-1 bit 0 at addr 3 -> fail=1, fail_addr=3, fail_elem=1; done still asserted on schedule.
REQ-041 Stuck-at-0 bit 7 at addr 60 -> fail=1, fail_addr=60, fail_elem=2.
REQ-042 busy=0: csin=1, rwbarin=0, address=5, datain=8'hDE, then read -> mem_rdata 8'hDE; busy=1 with csin=1 -> mem_addr follows BIST sequence, not address.
REQ-043 rst=1 during M3 -> next edge busy=0, fail=0, done=0; new start runs full 642-edge sequence.
REQ-044 Second start pulse mid-RUN -> ignored; done timing of first run unchanged.
